// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - servo PWM pulse-width to position decoder with frame-loss detection
// Optional glitch filter on the synchronized input: define SERVO_DEC_GLITCH_FILTER_EN.
module servo_pulse_decoder #(
  parameter int  CLK_FREQUENCY     = 50000000,
  parameter int  VALUE_SCALING     = 256,
  parameter int  POSITION_DATA_LEN = 8,
  parameter real SPEED_MAX_PERIOD  = 0.03
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         servo_in,
  output logic [POSITION_DATA_LEN-1:0] position,
  output logic                         position_valid,
  output logic                         pulse_err,
  output logic                         frame_lost
);

  localparam int MIN_CLKS     = CLK_FREQUENCY / 1000;
  localparam int STEP_RAW     = MIN_CLKS / VALUE_SCALING;
  localparam int STEP_CLKS    = (STEP_RAW < 1) ? 1 : STEP_RAW;
  localparam int GLITCH_CLKS  = MIN_CLKS / 2;
  localparam int LONG_CLKS    = 2 * MIN_CLKS + GLITCH_CLKS;
  localparam int TIMEOUT_CLKS = int'(CLK_FREQUENCY * SPEED_MAX_PERIOD);

  localparam int CW = $clog2(LONG_CLKS + 1);
  localparam int SW = $clog2(STEP_CLKS + 1);
  localparam int FW = $clog2(TIMEOUT_CLKS + 1);
  localparam int PL = POSITION_DATA_LEN;

  localparam logic [PL-1:0] ACC_MAX = PL'(VALUE_SCALING - 1);

  typedef enum logic [1:0] {IDLE, DEADBAND, MEASURE, DRAIN} state_t;

  logic s1, s2, s, s_d, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= servo_in;
      s2 <= s1;
    end
  end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  logic [1:0] flt_cnt;
  logic       s_f;

  // Level is accepted only after it differs from the filtered value for 4 clocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_f     <= 1'b0;
      flt_cnt <= 2'd0;
    end else if (s2 != s_f) begin
      if (flt_cnt == 2'd3) begin
        s_f     <= s2;
        flt_cnt <= 2'd0;
      end else begin
        flt_cnt <= flt_cnt + 2'd1;
      end
    end else begin
      flt_cnt <= 2'd0;
    end
  end

  assign s = s_f;
`else
  assign s = s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_d    <= s;
      rise_q <= s & ~s_d;
      fall_q <= ~s & s_d;
    end
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   w;
  logic [SW-1:0]   step;
  logic [PL-1:0]   acc;
  logic [PL-1:0]   acc_nxt;
  logic            step_wrap;
  logic [FW-1:0]   fcnt;

  // w is the high width including the current clock; acc_nxt already accounts for it.
  assign w         = cnt + CW'(1);
  assign step_wrap = (step == SW'(STEP_CLKS - 1));
  assign acc_nxt   = (step_wrap && acc != ACC_MAX) ? acc + PL'(1) : acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      step           <= '0;
      acc            <= '0;
      fcnt           <= '0;
      position       <= '0;
      position_valid <= 1'b0;
      pulse_err      <= 1'b0;
      frame_lost     <= 1'b1;
    end else begin
      position_valid <= 1'b0;
      pulse_err      <= 1'b0;
      if (fcnt != FW'(TIMEOUT_CLKS)) fcnt <= fcnt + FW'(1);
      if (fcnt == FW'(TIMEOUT_CLKS - 1)) frame_lost <= 1'b1;

      case (state)
        IDLE: begin
          if (rise_q) begin
            state <= DEADBAND;
            cnt   <= '0;
          end
        end
        DEADBAND: begin
          cnt <= w;
          if (fall_q) begin
            state <= IDLE;
            if (w >= CW'(GLITCH_CLKS)) begin
              position       <= '0;
              position_valid <= 1'b1;
              frame_lost     <= 1'b0;
              fcnt           <= '0;
            end else begin
              pulse_err <= 1'b1;
            end
          end else if (w == CW'(MIN_CLKS)) begin
            state <= MEASURE;
            step  <= '0;
            acc   <= '0;
          end
        end
        MEASURE: begin
          cnt  <= w;
          step <= step_wrap ? '0 : step + SW'(1);
          acc  <= acc_nxt;
          if (w == CW'(LONG_CLKS)) begin
            pulse_err <= 1'b1;
            state     <= DRAIN;
          end else if (fall_q) begin
            position       <= acc_nxt;
            position_valid <= 1'b1;
            frame_lost     <= 1'b0;
            fcnt           <= '0;
            state          <= IDLE;
          end
        end
        DRAIN: begin
          if (!s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - randomized self-checking bench for servo_pulse_decoder
module tb_servo_pulse_decoder;

  localparam int CLK_HZ  = 256000;
  localparam int MIN     = CLK_HZ / 1000;
  localparam int STEP    = (MIN / 256 < 1) ? 1 : MIN / 256;
  localparam int GLITCH  = MIN / 2;
  localparam int LONG    = 2 * MIN + GLITCH;
  localparam int TIMEOUT = CLK_HZ * 3 / 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       servo_in = 1'b0;
  logic [7:0] position;
  logic       position_valid, pulse_err, frame_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcnt = 0, ecnt = 0, v_cyc = 0, e_cyc = 0, last_pos = 0;
  int model_pos = 0;

  servo_pulse_decoder #(.CLK_FREQUENCY(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .servo_in(servo_in), .position(position),
    .position_valid(position_valid), .pulse_err(pulse_err), .frame_lost(frame_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (position_valid || pulse_err) check("excl", int'(position_valid && pulse_err), 0);
    if (position_valid) begin
      vcnt++;
      v_cyc    = cyc;
      last_pos = position;
      check("fl_clear", frame_lost, 0);
    end
    if (pulse_err) begin
      ecnt++;
      e_cyc = cyc;
    end
  end

  task automatic pulse(input int h, input int gap);
    int v0, e0, r, f, ev, ep, ee;
    v0 = vcnt;
    e0 = ecnt;
    @(posedge clk); #1;
    servo_in = 1'b1;
    r = cyc;
    repeat (h) @(posedge clk);
    #1;
    servo_in = 1'b0;
    f = cyc;
    repeat (gap) @(posedge clk);
    #1;
    ev = 0; ep = 0; ee = 0;
    if (h >= LONG) ee = 1;
    else if (h >= MIN) begin ev = 1; ep = ((h - MIN) / STEP > 255) ? 255 : (h - MIN) / STEP; end
    else if (h >= GLITCH) ev = 1;
    else ee = 1;
    check($sformatf("valid_cnt h=%0d", h), vcnt - v0, ev);
    check($sformatf("err_cnt h=%0d", h), ecnt - e0, ee);
    if (ev != 0) begin
      check($sformatf("pos h=%0d", h), last_pos, ep);
      check($sformatf("lat h=%0d", h), v_cyc - f, 4);
      model_pos = ep;
    end else begin
      check($sformatf("pos_hold h=%0d", h), position, model_pos);
    end
    if (ee != 0) check($sformatf("err_lat h=%0d", h), e_cyc - ((h >= LONG) ? r + LONG : f), 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int v0, e0, n;
    repeat (4) @(posedge clk);
    #1;
    check("rst_pos", position, 0);
    check("rst_valid", position_valid, 0);
    check("rst_err", pulse_err, 0);
    check("rst_frame_lost", frame_lost, 1);
    rst = 1'b1;

    repeat (TIMEOUT) @(posedge clk);
    #1;
    check("fl_idle", frame_lost, 1);
    pulse(MIN + 128, 20);
    check("fl_after_valid", frame_lost, 0);
    pulse(100, 20);
    n = v_cyc + TIMEOUT - 1 - cyc;
    repeat (n) @(posedge clk);
    #1;
    check("fl_before_timeout", frame_lost, 0);
    @(posedge clk); #1;
    check("fl_timeout", frame_lost, 1);
    repeat (50) @(posedge clk);
    #1;
    check("fl_held", frame_lost, 1);

    pulse(512, 20);
    pulse(600, 20);
    pulse(200, 20);
    pulse(100, 20);
    pulse(700, 20);
    pulse(MIN + 128, 20);
    pulse(MIN, 20);
    pulse(GLITCH - 1, 20);
    pulse(GLITCH, 20);

    v0 = vcnt;
    e0 = ecnt;
    @(posedge clk); #1;
    servo_in = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pos", position, 0);
    check("mid_rst_valid", position_valid, 0);
    check("mid_rst_err", pulse_err, 0);
    check("mid_rst_frame_lost", frame_lost, 1);
    servo_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_no_valid", vcnt - v0, 0);
    check("mid_rst_no_err", ecnt - e0, 0);
    model_pos = 0;

    for (int i = 0; i < 16; i++) pulse(int'($urandom_range(20, 720)), int'($urandom_range(10, 40)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
